// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB interconnect slice: bus data width, default
// read data returned on error completions, and the transfer-tracking FSM
// state type.
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_DW = 32;

  localparam logic [APB_DW-1:0] APB_DEFAULT_RDATA = 32'hDEAD_BEEF;

  // IDLE covers both "no transfer" and the SETUP phase; ACCESS is the
  // PENABLE phase, possibly stretched by slave wait states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// -----------------------------------------------------------------------------
// apb_timeout_counter
// Saturating wait-state counter. Counts up on inc, holds at MAX_COUNT and
// raises expired once it gets there. clear has priority over inc.
//
// Ports:
//   clk      in  1  clock
//   srst     in  1  synchronous active-high reset
//   clear    in  1  return count to zero
//   inc      in  1  count one wait cycle
//   expired  out 1  count has reached MAX_COUNT
// -----------------------------------------------------------------------------
module apb_timeout_counter #(
  parameter int MAX_COUNT = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(MAX_COUNT + 1);

  logic [CW-1:0] count_reg;

  assign expired = (count_reg == CW'(MAX_COUNT));

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (inc && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/apb_interconnect.sv
// -----------------------------------------------------------------------------
// apb_interconnect
// One APB master fanned out to NUM_SLAVES slaves. The slave index is taken
// from PADDR[DEC_HI:DEC_LO]; indices >= NUM_SLAVES are unmapped and complete
// immediately with PSLVERR and DEFAULT_RDATA. PWRITE/PADDR/PWDATA are
// broadcast to the slaves outside this block.
//
// Optional feature (macro APB_IC_TIMEOUT_EN): an ACCESS-phase wait counter
// forces an error completion when a slave stalls for more than
// TIMEOUT_CYCLES cycles. Without the macro a mapped transfer waits on the
// slave indefinitely.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE   master control
//   PADDR, PWDATA           master address / write data
//   PREADY, PRDATA, PSLVERR response to master
//   PSEL_S, PENABLE_S       one-hot slave selects, slave enable
//   PREADY_S, PRDATA_S,     per-slave responses; slave i data at
//   PSLVERR_S               PRDATA_S[32i+31:32i]
// -----------------------------------------------------------------------------
module apb_interconnect
  import apb_pkg::*;
#(
  parameter int                NUM_SLAVES     = 4,
  parameter int                DEC_HI         = 23,
  parameter int                DEC_LO         = 16,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [APB_DW-1:0] DEFAULT_RDATA  = APB_DEFAULT_RDATA
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [APB_DW-1:0]            PADDR,
  input  logic [APB_DW-1:0]            PWDATA,
  output logic                         PREADY,
  output logic [APB_DW-1:0]            PRDATA,
  output logic                         PSLVERR,
  output logic [NUM_SLAVES-1:0]        PSEL_S,
  output logic                         PENABLE_S,
  input  logic [NUM_SLAVES-1:0]        PREADY_S,
  input  logic [APB_DW*NUM_SLAVES-1:0] PRDATA_S,
  input  logic [NUM_SLAVES-1:0]        PSLVERR_S
);

  localparam int DW = DEC_HI - DEC_LO + 1;

  // Write direction, write data and non-decode address bits only matter to
  // the slaves, which receive them directly.
  logic unused_inputs;
  assign unused_inputs = ^{PWRITE, PWDATA, PADDR};

  apb_state_e    state_reg, state_next;
  logic [DW-1:0] sel_reg;
  logic          mapped_reg;

  logic [DW-1:0]         idx;
  logic                  mapped;
  logic [NUM_SLAVES-1:0] idx_hit;
  logic [NUM_SLAVES-1:0] sel_hit;
  logic                  setup;

  logic              slave_ready;
  logic [APB_DW-1:0] slave_rdata;
  logic              slave_err;
  logic              timed_out;

  assign idx    = PADDR[DEC_HI:DEC_LO];
  // 9 bits holds any 8-bit field value and NUM_SLAVES up to 16.
  assign mapped = 9'(idx) < 9'(NUM_SLAVES);
  assign setup  = PSEL && !PENABLE;

  // Per-port match against the live decode (SETUP) and the latched one
  // (ACCESS). Out-of-range indices match nothing, so PSEL_S stays all-zero.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
    assign idx_hit[gi] = (idx == DW'(gi));
    assign sel_hit[gi] = (sel_reg == DW'(gi));
  end

  // Response mux: only the latched slave's outputs are looked at.
  always_comb begin
    slave_ready = 1'b0;
    slave_rdata = '0;
    slave_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_hit[i]) begin
        slave_ready = PREADY_S[i];
        slave_rdata = PRDATA_S[i*APB_DW +: APB_DW];
        slave_err   = PSLVERR_S[i];
      end
    end
  end

`ifdef APB_IC_TIMEOUT_EN
  logic wait_inc;

  assign wait_inc = (state_reg == ST_ACCESS) && PENABLE && mapped_reg && !slave_ready;

  // Held clear throughout IDLE, so every ACCESS phase starts from zero.
  apb_timeout_counter #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .srst    (PRESET),
    .clear   (state_reg == ST_IDLE),
    .inc     (wait_inc),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      mapped_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && setup) begin
        sel_reg    <= idx;
        mapped_reg <= mapped;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    PSEL_S     = '0;
    PENABLE_S  = 1'b0;
    PREADY     = 1'b0;
    PRDATA     = '0;
    PSLVERR    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (setup) begin
          state_next = ST_ACCESS;
          if (mapped) begin
            PSEL_S = idx_hit;
          end
        end
      end

      ST_ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer; selects already low by default.
          state_next = ST_IDLE;
        end else begin
          if (mapped_reg) begin
            PSEL_S    = sel_hit;
            PENABLE_S = PENABLE;
          end
          if (PENABLE) begin
            if (!mapped_reg) begin
              PREADY     = 1'b1;
              PSLVERR    = 1'b1;
              PRDATA     = DEFAULT_RDATA;
              state_next = ST_IDLE;
            end else if (slave_ready) begin
              // Checked before the timeout so a late-but-ready slave wins.
              PREADY     = 1'b1;
              PRDATA     = slave_rdata;
              PSLVERR    = slave_err;
              state_next = ST_IDLE;
            end else if (timed_out) begin
              PREADY     = 1'b1;
              PSLVERR    = 1'b1;
              PRDATA     = DEFAULT_RDATA;
              PSEL_S     = '0;
              PENABLE_S  = 1'b0;
              state_next = ST_IDLE;
            end
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // All master- and slave-facing outputs are quiet while reset is held.
    if (PRESET) begin
      PSEL_S    = '0;
      PENABLE_S = 1'b0;
      PREADY    = 1'b0;
      PRDATA    = '0;
      PSLVERR   = 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_interconnect.sv
// -----------------------------------------------------------------------------
// tb_apb_interconnect
// Drives APB transfers into apb_interconnect with behavioural slaves and
// checks every cycle against a transaction-level expectation: completion
// cycle, data and error derived from the decode / wait-state / timeout rules.
// Works with or without APB_IC_TIMEOUT_EN defined.
// -----------------------------------------------------------------------------
module tb_apb_interconnect;

  localparam int          NS    = 4;
  localparam int          T     = 16;
  localparam logic [31:0] DEF_D = 32'hDEAD_BEEF;

`ifdef APB_IC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           PCLK;
  logic           PRESET;
  logic           PSEL;
  logic           PENABLE;
  logic           PWRITE;
  logic [31:0]    PADDR;
  logic [31:0]    PWDATA;
  logic           PREADY;
  logic [31:0]    PRDATA;
  logic           PSLVERR;
  logic [NS-1:0]  PSEL_S;
  logic           PENABLE_S;
  logic [NS-1:0]  PREADY_S;
  logic [32*NS-1:0] PRDATA_S;
  logic [NS-1:0]  PSLVERR_S;

  int tests_run;
  int tests_failed;

  apb_interconnect #(
    .NUM_SLAVES     (NS),
    .DEC_HI         (23),
    .DEC_LO         (16),
    .TIMEOUT_CYCLES (T),
    .DEFAULT_RDATA  (DEF_D)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .PSEL_S    (PSEL_S),
    .PENABLE_S (PENABLE_S),
    .PREADY_S  (PREADY_S),
    .PRDATA_S  (PRDATA_S),
    .PSLVERR_S (PSLVERR_S)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Random noise on every slave port; the selected one is overridden after.
  task automatic drive_junk();
    PREADY_S  = NS'($urandom);
    PSLVERR_S = NS'($urandom);
    for (int s = 0; s < NS; s++) PRDATA_S[s*32 +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge PCLK);
      PRESET  = 1'b0;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      drive_junk();
      #1;
      check("idle_psel_s", 32'(PSEL_S), 32'd0);
      check("idle_pready", 32'(PREADY), 32'd0);
      check("idle_prdata", PRDATA, 32'd0);
    end
  endtask

  // One APB transfer. waits = slave wait states; abort_at / reset_at = ACCESS
  // cycle at which PSEL is dropped / PRESET is raised (0 = never).
  task automatic xfer(input logic [31:0] addr, input logic wr, input int waits,
                      input logic [31:0] data, input logic err,
                      input int abort_at, input int reset_at);
    int          idx;
    bit          mapped;
    int          exp_cycle;
    bit          exp_to;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  onehot;
    bit          done;
    bit          to_now;

    idx    = int'(addr[23:16]);
    mapped = (idx < NS);
    onehot = mapped ? 4'(1 << idx) : 4'b0000;
    if (!mapped) begin
      exp_cycle = 1; exp_to = 1'b0; exp_data = DEF_D; exp_err = 1'b1;
    end else if (TO_EN && waits > T) begin
      exp_cycle = T + 1; exp_to = 1'b1; exp_data = DEF_D; exp_err = 1'b1;
    end else begin
      exp_cycle = waits + 1; exp_to = 1'b0; exp_data = data; exp_err = err;
    end

    // SETUP
    @(negedge PCLK);
    PRESET  = 1'b0;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = $urandom;
    drive_junk();
    #1;
    check("setup_psel_s", 32'(PSEL_S), 32'(onehot));
    check("setup_penable_s", 32'(PENABLE_S), 32'd0);
    check("setup_pready", 32'(PREADY), 32'd0);

    // ACCESS
    for (int j = 1; j <= exp_cycle; j++) begin
      @(negedge PCLK);
      drive_junk();
      if (j == reset_at) begin
        PRESET = 1'b1;
        #1;
        check("rst_psel_s", 32'(PSEL_S), 32'd0);
        check("rst_penable_s", 32'(PENABLE_S), 32'd0);
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        $display("[TB] xfer addr=%08h reset in access cycle %0d", addr, j);
        return;
      end
      if (j == abort_at) begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        #1;
        check("abort_psel_s", 32'(PSEL_S), 32'd0);
        check("abort_penable_s", 32'(PENABLE_S), 32'd0);
        check("abort_pready", 32'(PREADY), 32'd0);
        $display("[TB] xfer addr=%08h aborted in access cycle %0d", addr, j);
        return;
      end
      PENABLE = 1'b1;
      if (mapped) begin
        PREADY_S[idx]         = (j > waits);
        PRDATA_S[idx*32 +: 32] = data;
        PSLVERR_S[idx]        = err;
      end
      #1;
      done   = (j == exp_cycle);
      to_now = done && exp_to;
      check("acc_psel_s", 32'(PSEL_S), (mapped && !to_now) ? 32'(onehot) : 32'd0);
      check("acc_penable_s", 32'(PENABLE_S), 32'(mapped && !to_now));
      check("acc_pready", 32'(PREADY), 32'(done));
      check("acc_prdata", PRDATA, done ? exp_data : 32'd0);
      check("acc_pslverr", 32'(PSLVERR), done ? 32'(exp_err) : 32'd0);
      if (done) begin
        $display("[TB] xfer addr=%08h wr=%0d waits=%0d done cycle=%0d rdata=%08h err=%0d",
                 addr, wr, waits, j, exp_data, exp_err);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  fld;
    int          w;
    int          r;
    int          ab;

    tests_run    = 0;
    tests_failed = 0;
    PRESET  = 1'b1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 32'h0002_0000;
    PWDATA  = '0;
    drive_junk();

    // Outputs held quiet during reset even with PSEL asserted.
    repeat (3) begin
      @(negedge PCLK);
      #1;
      check("reset_psel_s", 32'(PSEL_S), 32'd0);
      check("reset_penable_s", 32'(PENABLE_S), 32'd0);
      check("reset_pready", 32'(PREADY), 32'd0);
      check("reset_prdata", PRDATA, 32'd0);
      check("reset_pslverr", 32'(PSLVERR), 32'd0);
    end
    idle(2);

    // Directed cases
    xfer(32'h0002_0010, 1'b0, 0, 32'h1234_5678, 1'b0, 0, 0);
    xfer(32'h0001_0040, 1'b1, 3, 32'h0BAD_F00D, 1'b0, 0, 0);
    xfer(32'h0007_0000, 1'b0, 0, 32'h5555_AAAA, 1'b0, 0, 0);
    idle(1);
    // Stalled slave 0: timeout completion, or still pending after 100 cycles.
    xfer(32'h0000_0000, 1'b0, 1000, 32'h0101_0101, 1'b0, TO_EN ? 0 : 101, 0);
    idle(1);
    // Reset during ACCESS cycle 3, then a transfer straight after reset.
    xfer(32'h0000_0000, 1'b0, 1000, 32'h0202_0202, 1'b0, 0, 3);
    xfer(32'h0003_0004, 1'b0, 1, 32'hCAFE_0003, 1'b0, 0, 0);
    idle(1);
    // Back-to-back, no idle cycle.
    xfer(32'h0000_0008, 1'b0, 0, 32'hA0A0_0000, 1'b0, 0, 0);
    xfer(32'h0003_000C, 1'b0, 0, 32'hB3B3_0003, 1'b0, 0, 0);
    // Slave ready in the same cycle the timeout would fire.
    xfer(32'h0002_0000, 1'b0, T, 32'h7777_0002, 1'b1, 0, 0);
    xfer(32'hFF01_0000, 1'b1, 0, 32'h1111_0001, 1'b1, 0, 0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 7);
      fld = (r == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      a = {8'($urandom), fld, 16'($urandom)};
      r = $urandom_range(0, 9);
      if (r < 7)       w = $urandom_range(0, 4);
      else if (r == 7) w = T;
      else if (r == 8) w = T + 1 + $urandom_range(0, 4);
      else             w = 0;
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      xfer(a, 1'($urandom), w, $urandom, 1'($urandom), ab, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apb_interconnect.md
# apb_interconnect

Parametrised APB interconnect: one APB master port fanned out to `NUM_SLAVES` slave ports. Decodes a configurable address byte field and tracks each transfer with a SETUP/ACCESS state machine. Unmapped accesses and stalled slaves complete with `PSLVERR` rather than hanging the bus. It replaces the single-slave APB decoder and sits between the CPU-side APB bridge and the peripheral slaves.

## Interface
- `NUM_SLAVES`, 4: number of slave ports, 1..16.
- `DEC_HI`, 23: MSB of the decode field in `PADDR`.
- `DEC_LO`, 16: LSB of the decode field; field width `DEC_HI-DEC_LO+1` ≤ 8.
- `TIMEOUT_CYCLES`, 16: ACCESS wait cycles tolerated before forced error completion, ≥ 1.
- `DEFAULT_RDATA`, 32'hDEADBEEF: `PRDATA` returned on unmapped or timed-out transfers.

Ports:
- `PCLK`  in  1  bus clock; all state on rising edge.
- `PRESET`  in  1  reset, synchronous, active-high.
- `PSEL`  in  1  master select.
- `PENABLE`  in  1  master enable.
- `PWRITE`  in  1  write/read; broadcast to slaves externally.
- `PADDR`  in  32  address; broadcast to slaves externally.
- `PWDATA`  in  32  write data; broadcast to slaves externally.
- `PREADY`  out  1  transfer complete to master.
- `PRDATA`  out  32  read data to master.
- `PSLVERR`  out  1  error on completing transfer.
- `PSEL_S`  out  NUM_SLAVES  one-hot slave selects.
- `PENABLE_S`  out  1  enable to slaves.
- `PREADY_S`  in  NUM_SLAVES  per-slave ready.
- `PRDATA_S`  in  32*NUM_SLAVES  per-slave read data; slave i at bits [32i+31:32i].
- `PSLVERR_S`  in  NUM_SLAVES  per-slave error.

## Operation
- Decode: `idx = PADDR[DEC_HI:DEC_LO]`. Mapped iff `idx < NUM_SLAVES`; otherwise unmapped.
- FSM states: IDLE, ACCESS.
  - IDLE:
    - On `PSEL & !PENABLE` (SETUP phase), latch `sel_q = idx`, `mapped_q`, clear `wait_cnt`, go to ACCESS.
    - `PSEL_S[idx] = PSEL & !PENABLE & mapped`, combinational, so slaves see PSEL in the setup cycle.
  - ACCESS:
    - `PSEL_S[sel_q] = PSEL & mapped_q`; `PENABLE_S = PENABLE & mapped_q`.
    - Completion when `PENABLE` and one of the following holds:
      - (a) mapped and `PREADY_S[sel_q]`: pass through `PRDATA_S`/`PSLVERR_S` of `sel_q`.
      - (b) unmapped: `PREADY=1`, `PSLVERR=1`, `PRDATA=DEFAULT_RDATA`, zero wait states.
      - (c) timeout (see Configuration): `PREADY=1`, `PSLVERR=1`, `PRDATA=DEFAULT_RDATA`; `PSEL_S` and `PENABLE_S` forced low in that cycle.
    - On completion, next state is IDLE. A back-to-back SETUP is accepted in the following cycle.
    - Master drops `PSEL` in ACCESS (protocol abort): go to IDLE, no completion, slave selects low immediately.
- `wait_cnt` increments on each ACCESS cycle with `PENABLE & mapped_q & !PREADY_S[sel_q]`. It saturates at `TIMEOUT_CYCLES`.
- Outside a completing cycle: `PREADY=0`, `PSLVERR=0`, `PRDATA=0`.
- `PSEL_S` is one-hot or all-zero at all times.

## Timing
- Reset (synchronous, next edge, also mid-transfer):
  - state IDLE; `sel_q=0`, `mapped_q=0`, `wait_cnt=0`.
  - `PSEL_S=0`, `PENABLE_S=0`, `PREADY=0`, `PRDATA=0`, `PSLVERR=0` while `PRESET` high.
  - An in-flight transfer is dropped without completion.
- Latency: the interconnect adds zero cycles.
  - Mapped, zero-wait slave completes in the first ACCESS cycle (2-cycle APB transfer).
  - Unmapped access always completes in 2 cycles.
- Timeout: with `TIMEOUT_CYCLES=T`, a slave holding `PREADY_S` low forces completion in ACCESS cycle T+1.
- Simultaneous slave `PREADY_S` and timeout in the same cycle: the slave response wins, with `PSLVERR` taken from the slave.
- Slave outputs of non-selected ports are ignored.

## Configuration
- `APB_IC_TIMEOUT_EN` defined: `wait_cnt` and timeout completion (c) are compiled in.
- Undefined: no counter; a mapped transfer waits indefinitely on `PREADY_S`. Unmapped error completion (b) remains.

## Structure
- Package `apb_pkg` holds:
  - the FSM state enum;
  - `APB_DW=32`;
  - `APB_DEFAULT_RDATA=32'hDEADBEEF`, used as the default of `DEFAULT_RDATA`.
- Sub-module `apb_timeout_counter`: saturating counter with clear, increment enable and `expired` output. Instantiated only under `APB_IC_TIMEOUT_EN`.
- Decode and the response mux stay in `apb_interconnect`.

## Test plan
- Zero-wait read, `PADDR=32'h0002_0010`, `PRDATA_S` slot 2 = `32'h1234_5678`: `PSEL_S=4'b0100` in setup and access cycles; `PREADY=1`, `PRDATA=32'h1234_5678`, `PSLVERR=0` in cycle 2.
- Write to slave 1 with 3 wait states: `PSEL_S=4'b0010` held 5 cycles; `PREADY` high only in the 5th cycle; `wait_cnt` never reaches T.
- Unmapped read, `PADDR=32'h0007_0000`, `NUM_SLAVES=4`: `PSEL_S=0`; cycle 2 `PREADY=1`, `PSLVERR=1`, `PRDATA=32'hDEADBEEF`.
- Timeout, T=16, slave 0 holds `PREADY_S=0`: completion in ACCESS cycle 17 with `PSLVERR=1`, `PRDATA=32'hDEADBEEF`, `PSEL_S[0]=0` that cycle. Without the macro: no completion after 100 cycles.
- Reset asserted during ACCESS cycle 3 of a stalled transfer: next edge all outputs 0, state IDLE; a new transfer to slave 3 then completes normally.
- Back-to-back reads to slaves 0 then 3, no idle cycle: selects `0001, 0001, 1000, 1000`; both complete with correct data.
